// File: rtl/keypad_scanner_if.sv
// Keypad-side and controller-side signals of the keypad scanner.
// The master is the scanner itself; the slave is whatever sits on the other side.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] keypad;
  logic       confirm;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;

  modport master (
    input  row_in,
    output col_out,
    output keypad,
    output confirm,
    output key_valid,
    output key_held,
    output multi_key
  );

  modport slave (
    output row_in,
    input  col_out,
    input  keypad,
    input  confirm,
    input  key_valid,
    input  key_held,
    input  multi_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column scan, frame classification, debounce FSM,
// and a stable key code presented ahead of a stretched confirm strobe.
module keypad_scanner #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 5,
  parameter int CONFIRM_CYCLES  = 1000
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master kp
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int CONF_W = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_TARGET = DEB_W'(DEBOUNCE_FRAMES);
  localparam logic [CONF_W-1:0] CONF_LAST  = CONF_W'(CONFIRM_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_ACCEPT,
    S_STROBE,
    S_RELEASE
  } state_t;

  function automatic logic [2:0] count_closures(input logic [3:0] hits);
    return {2'b00, hits[0]} + {2'b00, hits[1]} + {2'b00, hits[2]} + {2'b00, hits[3]};
  endfunction

  function automatic logic [1:0] closure_row(input logic [3:0] hits);
    if (hits[0])      return 2'd0;
    else if (hits[1]) return 2'd1;
    else if (hits[2]) return 2'd2;
    else              return 2'd3;
  endfunction

  // Closure totals only need to distinguish none / one / several.
  function automatic logic [1:0] sat_closures(input logic [2:0] n);
    return (n > 3'd1) ? 2'd2 : n[1:0];
  endfunction

  logic [3:0]       row_p0;
  logic [3:0]       row_p1;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       acc_n;
  logic [3:0]       acc_code;
  logic             slot_last;
  logic             frame_eval;
  logic [3:0]       col_hits;
  logic [2:0]       col_n;
  logic [3:0]       col_code;
  logic [1:0]       frame_n;
  logic [3:0]       frame_code;
  logic             frame_none;
  logic             frame_single;
  logic             frame_multi;

  state_t            state;
  state_t            state_nx;
  logic [DEB_W-1:0]  deb_cnt;
  logic [DEB_W-1:0]  deb_cnt_nx;
  logic [3:0]        cand;
  logic [3:0]        cand_nx;
  logic [CONF_W-1:0] conf_cnt;
  logic [CONF_W-1:0] conf_cnt_nx;
  logic [3:0]        keypad_q;
  logic              key_held_q;
  logic              multi_key_q;
  logic              key_valid_c;
  logic              confirm_c;

  // Stage p0/p1: two-flop synchronizer for the asynchronous rows
  always_ff @(posedge clk) begin
    row_p0 <= kp.row_in;
    row_p1 <= row_p0;
  end

  // Column scan: one column slot every SCAN_DIV cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else if (slot_last) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign slot_last  = (div_cnt == DIV_LAST);
  assign frame_eval = slot_last && (col_idx == 2'd3);

  assign col_hits   = ~row_p1;
  assign col_n      = count_closures(col_hits);
  assign col_code   = {closure_row(col_hits), col_idx};
  assign frame_n    = sat_closures({1'b0, acc_n} + col_n);
  assign frame_code = (acc_n == 2'd0) ? col_code : acc_code;

  assign frame_none   = frame_eval && (frame_n == 2'd0);
  assign frame_single = frame_eval && (frame_n == 2'd1);
  assign frame_multi  = frame_eval && (frame_n == 2'd2);

  // Frame accumulation across the four column slots; restarts after column 3
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_n <= 2'd0;
    end else if (slot_last) begin
      acc_n <= (col_idx == 2'd3) ? 2'd0 : frame_n;
    end
  end

  always_ff @(posedge clk) begin
    if (slot_last) begin
      acc_code <= frame_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      multi_key_q <= 1'b0;
    end else if (frame_eval) begin
      multi_key_q <= frame_multi;
    end
  end

  // FSM state and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      deb_cnt  <= '0;
      cand     <= 4'h0;
      conf_cnt <= '0;
    end else begin
      state    <= state_nx;
      deb_cnt  <= deb_cnt_nx;
      cand     <= cand_nx;
      conf_cnt <= conf_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    deb_cnt_nx  = deb_cnt;
    cand_nx     = cand;
    conf_cnt_nx = conf_cnt;
    case (state)
      S_IDLE: begin
        if (frame_single) begin
          cand_nx    = frame_code;
          deb_cnt_nx = DEB_W'(1);
          state_nx   = (DEB_TARGET == DEB_W'(1)) ? S_ACCEPT : S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (frame_single && (frame_code == cand)) begin
          deb_cnt_nx = deb_cnt + 1'b1;
          if (deb_cnt_nx == DEB_TARGET) state_nx = S_ACCEPT;
        end else if (frame_eval) begin
          deb_cnt_nx = '0;
          state_nx   = S_IDLE;
        end
      end
      S_ACCEPT: begin
        deb_cnt_nx  = '0;
        conf_cnt_nx = '0;
        state_nx    = S_STROBE;
      end
      S_STROBE: begin
        // Frame results are deliberately ignored while confirm is high.
        if (conf_cnt == CONF_LAST) begin
          conf_cnt_nx = '0;
          deb_cnt_nx  = '0;
          state_nx    = S_RELEASE;
        end else begin
          conf_cnt_nx = conf_cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        if (frame_none) begin
          deb_cnt_nx = deb_cnt + 1'b1;
          if (deb_cnt_nx == DEB_TARGET) begin
            deb_cnt_nx = '0;
            state_nx   = S_IDLE;
          end
        end else if (frame_eval) begin
          deb_cnt_nx = '0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    key_valid_c = (state == S_ACCEPT);
    confirm_c   = (state == S_STROBE);
  end

  // Code and held flag change on the edge that enters ACCEPT, aligned with key_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      keypad_q   <= 4'h0;
      key_held_q <= 1'b0;
    end else if (state_nx == S_ACCEPT) begin
      keypad_q   <= cand_nx;
      key_held_q <= 1'b1;
    end else if ((state == S_RELEASE) && (state_nx == S_IDLE)) begin
      key_held_q <= 1'b0;
    end
  end

  assign kp.col_out   = ~(4'b0001 << col_idx);
  assign kp.keypad    = keypad_q;
  assign kp.confirm   = confirm_c;
  assign kp.key_valid = key_valid_c;
  assign kp.key_held  = key_held_q;
  assign kp.multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model driven from col_out, with a timed
// scoreboard of expected accepts checked against key_valid, keypad and confirm.
module tb_keypad_scanner;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_FRAMES = 3;
  localparam int CONFIRM_CYCLES  = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
    .CONFIRM_CYCLES  (CONFIRM_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  always #5 clk = ~clk;

  logic [15:0] pressed = '0;

  // Matrix model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    kif.row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.col_out[c]) kif.row_in[r] = 1'b0;
  end

  // cyc counts cycles since the last reset edge, matching the scan phase.
  int   cyc   = 0;
  logic rst_q = 1'b0;
  always @(posedge clk) begin
    rst_q <= reset;
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    logic [3:0] code;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input int obs, input int want);
    n_checks++;
    if (obs == want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cyc %0d", tag, obs, want, cyc);
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_cyc", cyc, n);
  endtask

  task automatic set_key(input logic [3:0] k, input logic v);
    pressed[k] = v;
  endtask

  task automatic expect_key(input logic [3:0] k, input int at);
    exp_t e;
    e.code = k;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Continuous monitor: scan order, accept timing, code stability, strobe width.
  bit         armed      = 1'b0;
  int         conf_left  = 0;
  logic [3:0] exp_keypad = 4'h0;
  logic [3:0] exp_col;
  logic       exp_kv;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_q) begin
        armed      = 1'b1;
        sb.delete();
        conf_left  = 0;
        exp_keypad = 4'h0;
      end
      if (armed) begin
        exp_col = ~(4'b0001 << cyc[3:2]);
        exp_kv  = (sb.size() > 0) && (sb[0].at == cyc);
        if (exp_kv) begin
          exp_keypad = sb[0].code;
          void'(sb.pop_front());
        end
        chk("col_out",   int'(kif.col_out),   int'(exp_col));
        chk("key_valid", int'(kif.key_valid), int'(exp_kv));
        chk("keypad",    int'(kif.keypad),    int'(exp_keypad));
        chk("confirm",   int'(kif.confirm),   int'(conf_left > 0));
        if (conf_left > 0) conf_left--;
        if (exp_kv) conf_left = CONFIRM_CYCLES;
      end
    end
  end

  initial begin
    repeat (4) @(negedge clk);
    reset = 1'b0;

    // Idle scan
    wait_cyc(63);
    chk("idle_held",  int'(kif.key_held),  0);
    chk("idle_multi", int'(kif.multi_key), 0);

    // Clean press of 9 held for 100 cycles
    wait_cyc(64);
    set_key(4'h9, 1'b1);
    expect_key(4'h9, 112);
    wait_cyc(111); chk("held_before_accept", int'(kif.key_held), 0);
    wait_cyc(112); chk("held_at_accept",     int'(kif.key_held), 1);
    wait_cyc(164); set_key(4'h9, 1'b0);
    wait_cyc(207); chk("held_before_release", int'(kif.key_held), 1);
    wait_cyc(208); chk("held_after_release",  int'(kif.key_held), 0);

    // Bouncy press of 0, then hold; accept after three clean frames
    wait_cyc(230); set_key(4'h0, 1'b1);
    expect_key(4'h0, 352);
    wait_cyc(240); set_key(4'h0, 1'b0);
    wait_cyc(250); set_key(4'h0, 1'b1);
    wait_cyc(260); set_key(4'h0, 1'b0);
    wait_cyc(270); set_key(4'h0, 1'b1);
    wait_cyc(280); set_key(4'h0, 1'b0);
    wait_cyc(290); set_key(4'h0, 1'b1);
    wait_cyc(351); chk("bounce_no_held", int'(kif.key_held), 0);
    wait_cyc(368); set_key(4'h0, 1'b0);
    wait_cyc(415); chk("bounce_held", int'(kif.key_held), 1);
    wait_cyc(416); chk("bounce_rel",  int'(kif.key_held), 0);

    // Two keys together, then drop one
    wait_cyc(432);
    set_key(4'h3, 1'b1);
    set_key(4'hC, 1'b1);
    wait_cyc(447); chk("multi_before", int'(kif.multi_key), 0);
    wait_cyc(448); chk("multi_set",    int'(kif.multi_key), 1);
    wait_cyc(460); chk("multi_no_held", int'(kif.key_held), 0);
    wait_cyc(472);
    set_key(4'hC, 1'b0);
    expect_key(4'h3, 528);
    wait_cyc(495); chk("multi_still", int'(kif.multi_key), 1);
    wait_cyc(496); chk("multi_clear", int'(kif.multi_key), 0);
    wait_cyc(544); set_key(4'h3, 1'b0);
    wait_cyc(592); chk("k3_released", int'(kif.key_held), 0);

    // Relock code F, release, then 5
    wait_cyc(608); set_key(4'hF, 1'b1);
    expect_key(4'hF, 656);
    wait_cyc(672); set_key(4'hF, 1'b0);
    wait_cyc(720); chk("kF_released", int'(kif.key_held), 0);
    wait_cyc(736); set_key(4'h5, 1'b1);
    expect_key(4'h5, 784);
    wait_cyc(800); set_key(4'h5, 1'b0);
    wait_cyc(848); chk("k5_released", int'(kif.key_held), 0);

    // Reset in the third confirm cycle with the key still held
    wait_cyc(864); set_key(4'h6, 1'b1);
    expect_key(4'h6, 912);
    wait_cyc(915);
    chk("pre_rst_confirm", int'(kif.confirm),  1);
    chk("pre_rst_held",    int'(kif.key_held), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_confirm", int'(kif.confirm),   0);
    chk("rst_held",    int'(kif.key_held),  0);
    chk("rst_keypad",  int'(kif.keypad),    0);
    chk("rst_col",     int'(kif.col_out),   4'hE);
    chk("rst_multi",   int'(kif.multi_key), 0);
    wait_cyc(1);
    expect_key(4'h6, 48);
    wait_cyc(64);  set_key(4'h6, 1'b0);
    wait_cyc(111); chk("re_held",     int'(kif.key_held), 1);
    wait_cyc(112); chk("re_released", int'(kif.key_held), 0);

    wait_cyc(130);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
